// File: rtl/dmem_uart_tx_if.sv
// rtl/dmem_uart_tx_if.sv - dmem bus bundle between the core (master) and a memory-mapped responder
interface dmem_uart_tx_if;
    logic        dmem_req;
    logic        dmem_wr_en;
    logic [1:0]  dmem_size;          // 0 = byte, 1 = half, 2 = word
    logic        dmem_zero_extend;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wr_data;
    logic [31:0] dmem_rd_data;
    logic        dmem_hit;

    modport master (
        output dmem_req, dmem_wr_en, dmem_size, dmem_zero_extend, dmem_addr, dmem_wr_data,
        input  dmem_rd_data, dmem_hit
    );

    modport slave (
        input  dmem_req, dmem_wr_en, dmem_size, dmem_zero_extend, dmem_addr, dmem_wr_data,
        output dmem_rd_data, dmem_hit
    );
endinterface

// File: rtl/dmem_uart_tx.sv
// rtl/dmem_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO on the dmem bus
module dmem_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd15
) (
    input  logic           clk,
    input  logic           reset_n,
    dmem_uart_tx_if.slave  bus,
    output logic           uart_tx,
    output logic           tx_irq
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_baud;
    logic        r_ovf;
    logic [AW:0] r_wptr, r_rptr;
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [7:0]  r_shift, w_shift_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [15:0] r_fdiv, w_fdiv_nxt;
    logic [2:0]  r_idx, w_idx_nxt;
    logic        r_tx, w_tx_nxt;

    logic        w_hit, w_wr, w_push_req, w_push, w_pop;
    logic        w_empty, w_full, w_busy, w_bit_done;
    logic [AW:0] w_count;
    logic [2:0]  w_idx_inc;
    logic [31:0] w_reg, w_rd;
    logic        w_unused_bits;

    assign w_hit      = bus.dmem_req && (bus.dmem_addr[31:4] == BASE_ADDR[31:4]);
    assign w_wr       = w_hit && bus.dmem_wr_en;
    assign w_push_req = w_wr && (bus.dmem_addr[3:2] == 2'd0);
    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_count    = r_wptr - r_rptr;
    // A pop on the same edge frees the slot the new byte lands in, so full does not block it.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_busy     = (r_state != S_IDLE);
    assign w_bit_done = (r_cnt == 16'd0);
    assign w_idx_inc  = r_idx + 3'd1;

    assign w_unused_bits = ^{bus.dmem_zero_extend, bus.dmem_addr[1:0], bus.dmem_wr_data[31:16]};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= bus.dmem_wr_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
            r_baud <= DEFAULT_DIV;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push_req && !w_push) begin
                r_ovf <= 1'b1;
            end else if (w_wr && bus.dmem_addr[3:2] == 2'd1 && bus.dmem_wr_data[3]) begin
                r_ovf <= 1'b0;
            end
            if (w_wr && bus.dmem_addr[3:2] == 2'd2) begin
                r_baud <= bus.dmem_wr_data[15:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_shift <= 8'd0;
            r_cnt   <= 16'd0;
            r_fdiv  <= 16'd0;
            r_idx   <= 3'd0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fdiv  <= w_fdiv_nxt;
            r_idx   <= w_idx_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // The divider is captured per frame so BAUDDIV writes only take effect at the next pop.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_fdiv_nxt  = r_fdiv;
        w_idx_nxt   = r_idx;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                    w_shift_nxt = r_mem[r_rptr[AW-1:0]];
                    w_fdiv_nxt  = r_baud;
                    w_cnt_nxt   = r_baud;
                    w_tx_nxt    = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_done) begin
                    w_state_nxt = S_DATA;
                    w_idx_nxt   = 3'd0;
                    w_tx_nxt    = r_shift[0];
                    w_cnt_nxt   = r_fdiv;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    w_cnt_nxt = r_fdiv;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_idx_nxt = w_idx_inc;
                        w_tx_nxt  = r_shift[w_idx_inc];
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            S_STOP: begin
                if (w_bit_done) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_START;
                        w_shift_nxt = r_mem[r_rptr[AW-1:0]];
                        w_fdiv_nxt  = r_baud;
                        w_cnt_nxt   = r_baud;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_reg = 32'd0;
        case (bus.dmem_addr[3:2])
            2'd1:    w_reg = {16'd0, {(7-AW){1'b0}}, w_count, 4'd0, r_ovf, w_empty, w_full, w_busy};
            2'd2:    w_reg = {16'd0, r_baud};
            default: w_reg = 32'd0;
        endcase
        case (bus.dmem_size)
            2'd0:    w_rd = w_reg & 32'h0000_00FF;
            2'd1:    w_rd = w_reg & 32'h0000_FFFF;
            default: w_rd = w_reg;
        endcase
        if (!w_hit) begin
            w_rd = 32'd0;
        end
    end

    assign bus.dmem_rd_data = w_rd;
    assign bus.dmem_hit     = w_hit;
    assign uart_tx          = r_tx;
    assign tx_irq           = w_empty && !w_busy;
endmodule
